btn_toggle_gen: RTL and testbench

Debounced toggle-request generator. Feeds the `t` input of the synchronous T flip-flop stage. Takes a raw asynchronous push-button level and emits exactly one single-cycle toggle pulse per debounced press, with optional auto-repeat while the button is held. Also exposes the debounced level and a wrap-around pulse counter for observability.

---
 rtl/btn_toggle_gen_if.sv | 25 ++
 rtl/btn_toggle_gen.sv | 126 ++++++++++++
 tb/tb_btn_toggle_gen.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/btn_toggle_gen_if.sv
// Button/toggle bundle: raw button and enable in, toggle pulse, debounced level and pulse count out.
// Pure wiring, no latency and no backpressure.
interface btn_toggle_gen_if;
  logic       btn_in;
  logic       en;
  logic       t;
  logic       btn_level;
  logic [7:0] pulse_cnt;

  modport master (
    output btn_in,
    output en,
    input  t,
    input  btn_level,
    input  pulse_cnt
  );

  modport slave (
    input  btn_in,
    input  en,
    output t,
    output btn_level,
    output pulse_cnt
  );
endinterface

// File: rtl/btn_toggle_gen.sv
// Debounced push-button to single-cycle toggle pulse, with optional auto-repeat while held.
// Press pulse DB_CYCLES+3 edges after btn_in is first sampled high; no backpressure, en only masks pulses.
module btn_toggle_gen #(
  parameter int DB_CYCLES     = 4,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 8,
  parameter int CNT_W         = 16
) (
  input  logic            clk,
  input  logic            rst,
  btn_toggle_gen_if.slave bus
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] TMR_MAX  = '1;
  localparam bit               RPT_ON   = (REPEAT_DELAY != 0);

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    REPEAT,
    DEB_RELEASE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       sync_q;
  logic             btn_s;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_nxt;
  logic             level_q;
  logic             level_nxt;
  logic             pulse_ev;
  logic             t_q;
  logic [7:0]       cnt_q;

  // Capture flop then two synchronizer stages; btn_s is the last stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], bus.btn_in};
    end
  end

  assign btn_s = sync_q[2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = (timer == TMR_MAX) ? timer : timer + CNT_W'(1);
    level_nxt = level_q;
    pulse_ev  = 1'b0;
    case (state)
      IDLE: begin
        timer_nxt = '0;
        if (btn_s) state_nxt = DEB_PRESS;
      end
      DEB_PRESS: begin
        if (!btn_s) begin
          state_nxt = IDLE;
        end else if (timer == DB_LAST) begin
          state_nxt = PRESSED;
          level_nxt = 1'b1;
          pulse_ev  = 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_nxt = DEB_RELEASE;
        end else if (RPT_ON && timer == RD_LAST) begin
          state_nxt = REPEAT;
          pulse_ev  = 1'b1;
        end
      end
      REPEAT: begin
        if (!btn_s) begin
          state_nxt = DEB_RELEASE;
        end else if (timer == RP_LAST) begin
          pulse_ev  = 1'b1;
          timer_nxt = '0;
        end
      end
      DEB_RELEASE: begin
        if (btn_s) begin
          state_nxt = PRESSED;
        end else if (timer == DB_LAST) begin
          state_nxt = IDLE;
          level_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Every state change restarts the timer, including a bounce back into PRESSED.
    if (state_nxt != state) timer_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= 1'b0;
      t_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_nxt;
      t_q     <= pulse_ev & bus.en;
      if (pulse_ev && bus.en) cnt_q <= cnt_q + 8'd1;
    end
  end

  assign bus.t         = t_q;
  assign bus.btn_level = level_q;
  assign bus.pulse_cnt = cnt_q;

endmodule

// File: tb/tb_btn_toggle_gen.sv
// Bench for btn_toggle_gen: a default instance and an auto-repeat instance share one stimulus stream.
// Directed vector table, hand-written corner sequences, and a random phase against a run-length reference model.
module tb_btn_toggle_gen;

  logic clk;
  logic rst;
  logic btn;
  logic en;

  int total = 0;
  int bad   = 0;

  btn_toggle_gen_if ifa ();
  btn_toggle_gen_if ifb ();

  assign ifa.btn_in = btn;
  assign ifa.en     = en;
  assign ifb.btn_in = btn;
  assign ifb.en     = en;

  btn_toggle_gen #(.DB_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(8), .CNT_W(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  btn_toggle_gen #(.DB_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(4), .CNT_W(16)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: the FSM sees btn_in three edges late; the level flips after DB+1
  // consecutive samples disagreeing with it; repeats fall on anchor+RD+k*RP.
  bit         pipe [3];
  int         m_run [2];
  int         m_anchor [2];
  bit         m_level [2];
  bit         m_t [2];
  logic [7:0] m_cnt [2];
  int         ncyc;
  bit         m_s;

  task automatic model_step(int k, bit s, bit e);
    int  dbv;
    int  rdv;
    int  rpv;
    int  d;
    bit  pulse;
    dbv   = 4;
    rdv   = (k == 1) ? 10 : 0;
    rpv   = (k == 1) ? 4 : 8;
    pulse = 1'b0;
    if (!m_level[k]) begin
      m_run[k] = s ? m_run[k] + 1 : 0;
      if (m_run[k] == dbv + 1) begin
        m_level[k]  = 1'b1;
        m_run[k]    = 0;
        m_anchor[k] = ncyc;
        pulse       = 1'b1;
      end
    end else if (!s) begin
      m_run[k]++;
      if (m_run[k] == dbv + 1) begin
        m_level[k] = 1'b0;
        m_run[k]   = 0;
      end
    end else if (m_run[k] != 0) begin
      m_run[k]    = 0;
      m_anchor[k] = ncyc;
    end else if (rdv != 0) begin
      d = ncyc - m_anchor[k];
      if (d >= rdv && (d - rdv) % rpv == 0) pulse = 1'b1;
    end
    m_t[k] = pulse && e;
    if (m_t[k]) m_cnt[k] = m_cnt[k] + 8'd1;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) pipe[k] = 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_run[k]    = 0;
        m_anchor[k] = 0;
        m_level[k]  = 1'b0;
        m_t[k]      = 1'b0;
        m_cnt[k]    = 8'd0;
      end
    end else begin
      m_s     = pipe[2];
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = btn;
      model_step(0, m_s, en);
      model_step(1, m_s, en);
      ncyc++;
    end
  end

  always @(negedge clk) begin
    check("live_a", int'({ifa.t, ifa.btn_level, ifa.pulse_cnt}), int'({m_t[0], m_level[0], m_cnt[0]}));
    check("live_b", int'({ifb.t, ifb.btn_level, ifb.pulse_cnt}), int'({m_t[1], m_level[1], m_cnt[1]}));
  end

  // Sequence runner: pat[i] is btn_in at edge i; en is low for edges en_lo..en_hi.
  bit         pat [$];
  int         qa [$];
  int         qb [$];
  int         rise_a;
  int         fall_a;
  int         nfall_a;
  logic [7:0] cnt0_a;
  logic [7:0] cnt0_b;
  logic [7:0] tcnt_a;
  logic [7:0] dcnt;

  task automatic add(bit v, int n);
    for (int i = 0; i < n; i++) pat.push_back(v);
  endtask

  task automatic run_seq(int en_lo, int en_hi);
    bit prev;
    qa.delete();
    qb.delete();
    rise_a  = -1;
    fall_a  = -1;
    nfall_a = 0;
    tcnt_a  = 8'hAA;
    cnt0_a  = ifa.pulse_cnt;
    cnt0_b  = ifb.pulse_cnt;
    prev    = ifa.btn_level;
    foreach (pat[i]) begin
      @(negedge clk);
      btn = pat[i];
      en  = !(i >= en_lo && i <= en_hi);
      @(posedge clk);
      #1;
      if (ifa.t) begin
        qa.push_back(i);
        tcnt_a = ifa.pulse_cnt;
      end
      if (ifb.t) qb.push_back(i);
      if (ifa.btn_level && !prev) rise_a = i;
      if (!ifa.btn_level && prev) begin
        fall_a = i;
        nfall_a++;
      end
      prev = ifa.btn_level;
    end
    en = 1'b1;
    pat.delete();
  endtask

  typedef struct {
    int hi;
    int lo;
    int en_lo;
    int en_hi;
    int n_t;
    int t_edge;
    int rise;
    int fall;
  } vec_t;

  vec_t vecs [6];
  int   exp_q [$];
  int   first;
  int   npress;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{20, 20, -1, -1, 1,  7, 7, 27};
    vecs[1] = '{ 3, 20, -1, -1, 0, -1, -1, -1};
    vecs[2] = '{ 4, 20, -1, -1, 0, -1, -1, -1};
    vecs[3] = '{ 5, 20, -1, -1, 1,  7, 7, 12};
    vecs[4] = '{20, 20,  0, 39, 0, -1, 7, 27};
    vecs[5] = '{20, 20,  7,  7, 0, -1, 7, 27};

    rst = 1'b1;
    btn = 1'b0;
    en  = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_t", int'(ifa.t), 0);
    check("reset_level", int'(ifa.btn_level), 0);
    check("reset_cnt", int'(ifa.pulse_cnt), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    foreach (vecs[r]) begin
      add(1'b1, vecs[r].hi);
      add(1'b0, vecs[r].lo);
      run_seq(vecs[r].en_lo, vecs[r].en_hi);
      dcnt = ifa.pulse_cnt - cnt0_a;
      check($sformatf("row%0d_npulse", r), qa.size(), vecs[r].n_t);
      check($sformatf("row%0d_t_edge", r), (qa.size() > 0) ? qa[0] : -1, vecs[r].t_edge);
      check($sformatf("row%0d_rise", r), rise_a, vecs[r].rise);
      check($sformatf("row%0d_fall", r), fall_a, vecs[r].fall);
      check($sformatf("row%0d_cnt", r), int'(dcnt), vecs[r].n_t);
    end

    // Release bounce: low 2, high 2 must neither pulse nor drop the level twice.
    add(1'b1, 30); add(1'b0, 2); add(1'b1, 2); add(1'b0, 20);
    run_seq(-1, -1);
    dcnt = ifa.pulse_cnt - cnt0_a;
    check("bounce_npulse", qa.size(), 1);
    check("bounce_nfall", nfall_a, 1);
    check("bounce_fall", fall_a, 41);
    check("bounce_cnt", int'(dcnt), 1);

    // Auto-repeat on instance b: 7, then +10, then every 4 while held.
    exp_q = '{7, 17, 21, 25, 29, 33, 37, 41};
    add(1'b1, 40); add(1'b0, 20);
    run_seq(-1, -1);
    check("rpt_npulse", qb.size(), exp_q.size());
    foreach (exp_q[j]) check($sformatf("rpt_edge%0d", j), (j < qb.size()) ? qb[j] : -1, exp_q[j]);

    exp_q = '{7, 25, 29, 33, 37, 41};
    add(1'b1, 40); add(1'b0, 20);
    run_seq(15, 22);
    dcnt = ifb.pulse_cnt - cnt0_b;
    check("gate_npulse", qb.size(), exp_q.size());
    foreach (exp_q[j]) check($sformatf("gate_edge%0d", j), (j < qb.size()) ? qb[j] : -1, exp_q[j]);
    check("gate_cnt", int'(dcnt), exp_q.size());

    // Reset while held, then a fresh debounce with the button still down.
    @(negedge clk);
    btn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("pre_rst_level", int'(ifa.btn_level), 1);
    #1 rst = 1'b0;
    #1;
    check("rst_t", int'(ifa.t), 0);
    check("rst_level", int'(ifa.btn_level), 0);
    check("rst_cnt", int'(ifa.pulse_cnt), 0);
    @(negedge clk);
    rst   = 1'b1;
    first = -1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (ifa.t && first < 0) first = i;
    end
    check("rst_repress_edge", first, 7);
    check("rst_repress_cnt", int'(ifa.pulse_cnt), 1);
    @(negedge clk);
    btn = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    // 256 presses from a cleared counter wrap it back to zero on the last pulse.
    @(negedge clk);
    #1 rst = 1'b0;
    #2 rst = 1'b1;
    check("wrap_start", int'(ifa.pulse_cnt), 0);
    npress = 0;
    for (int p = 1; p <= 256; p++) begin
      add(1'b1, 5);
      add(1'b0, 9);
      run_seq(-1, -1);
      npress += qa.size();
      if (p == 255) check("wrap_255", int'(ifa.pulse_cnt), 255);
      if (p == 256) check("wrap_t_cnt", int'(tcnt_a), 0);
    end
    check("wrap_npulse", npress, 256);
    check("wrap_end", int'(ifa.pulse_cnt), 0);

    // Random phase: held runs of random length, sparse en drops and rare resets.
    begin
      int hold;
      hold = 0;
      for (int i = 0; i < 2500; i++) begin
        @(negedge clk);
        if (hold == 0) begin
          btn  = 1'($urandom_range(0, 1));
          hold = $urandom_range(1, 14);
        end
        hold--;
        en = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 499) == 0) begin
          #1 rst = 1'b0;
          #2 rst = 1'b1;
        end
      end
    end
    @(negedge clk);
    btn = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
